pc_unit_ras: RTL
================

Name: pc_unit_ras

Overview:
- Parametrised next-generation program counter for the single-cycle core.
- Generalises address width, reset vector and sequential step.
- Adds pipeline stall, register-indirect jump, call/return with a hardware return-address stack (RAS), and sticky stack error flags.
- Drives the instruction-memory address; sits between the control unit/ALU (branch, zero) and instruction fetch.

Parameters:
- WIDTH, 32, PC and target width in bits.
- JADDR_W, 26, width of the absolute jump address field.
- STEP, 1, sequential increment (1 = word-addressed; 4 = byte-addressed).
- RESET_VEC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and RAS this cycle.
- branch  input  1  conditional branch instruction.
- zero  input  1  ALU zero flag; branch taken when branch&zero.
- boffset  input  WIDTH  signed branch offset, in STEP units.
- jump  input  1  absolute jump.
- call  input  1  absolute jump and push return address.
- jaddr  input  JADDR_W  absolute jump/call target, zero-extended to WIDTH.
- jr  input  1  register-indirect jump.
- jr_target  input  WIDTH  register-indirect target.
- ret  input  1  pop RAS and jump to the popped address.
- pc  output  WIDTH  current PC.
- pc_plus  output  WIDTH  pc+STEP, combinational.
- ras_depth  output  clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_empty  output  1  ras_depth==0, combinational.
- ras_full  output  1  ras_depth==RAS_DEPTH, combinational.
- ras_ovf  output  1  sticky: push occurred while full.
- ras_unf  output  1  sticky: ret issued while empty.

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc=RESET_VEC.
  - RAS pointer and depth = 0.
  - ras_ovf=0, ras_unf=0.
  - Entry contents don't-care.
- All updates occur on rising clk while reset=0.
- stall=1:
  - pc, RAS and flags hold; all other inputs ignored.
  - stall has priority over every control input.
- Next-PC priority, highest first (one action per cycle):
  1. ret:
     - If RAS not empty: pc=top entry, depth-1.
     - If empty: pc=pc+STEP, ras_unf<=1, depth stays 0.
  2. jr: pc=jr_target.
  3. call:
     - pc=zext(jaddr); push pc+STEP.
  4. jump: pc=zext(jaddr).
  5. branch&zero: pc=pc+STEP+(boffset*STEP), sign-extended, modulo 2^WIDTH.
  6. Otherwise: pc=pc+STEP.
- A lower-priority control asserted together with a higher one has no effect. Example: call+ret executes ret only, with no push.
- Arithmetic:
  - All additions are WIDTH bits and wrap silently.
  - pc at 2^WIDTH-STEP plus increment yields 0.
- RAS is a circular buffer with a top pointer.
  - Push when not full: write entry, pointer+1, depth+1.
  - Push when full: overwrite the oldest entry (pointer wraps), depth stays RAS_DEPTH, ras_ovf<=1.
  - Pop returns the most recent push (LIFO), including after an overflow.
  - A pop after overflow loses only the discarded oldest entries.
- Flags clear only on reset.
- Latency:
  - pc reflects the decision one clock after the inputs are sampled.
  - pc_plus and the full/empty status flags are combinational from state.
- No X propagation: the target used for ret is the stored entry only; an empty pop never reads the array.

Test Plan:
- Reset and sequential run (RESET_VEC=0, STEP=1): release reset, 3 idle clocks -> pc=0,1,2,3; pc_plus=pc+1. Assert reset asynchronously mid-cycle -> pc=0 immediately.
- Branch: at pc=10, branch=1, zero=1, boffset=-3 -> pc=8. Same with zero=0 -> pc=11. With STEP=4 at pc=40, boffset=2 -> pc=52.
- Call/return nesting: at pc=5, call jaddr=100 -> pc=100, depth=1. At pc=100, call jaddr=200 -> depth=2. ret -> pc=101. ret -> pc=6, ras_empty=1.
- Overflow (RAS_DEPTH=4): 5 consecutive calls from pc=0 to targets 10,20,30,40,50 -> ras_ovf=1, depth=4. Then 4 rets -> pc=41,31,21,11. 5th ret -> pc=12, ras_unf=1.
- Priority and stall: ret+call+jump together with depth=1 (top=77) -> pc=77, depth=0. jr+jump, jr_target=0x300 -> pc=0x300. stall=1 with jump held 3 clocks -> pc and depth unchanged.
- Wrap (WIDTH=8, STEP=1): pc=255, idle clock -> pc=0. Branch boffset=1 at pc=254 -> pc=0.

Source files
------------

// File: rtl/pc_unit_ras.sv
// ============================================================================
//  Module   : pc_unit_ras
//  Purpose  : Program counter with branch/jump/jr/call/ret and a circular
//             return-address stack carrying sticky overflow/underflow flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_unit_ras #(
  parameter int               WIDTH     = 32,
  parameter int               JADDR_W   = 26,
  parameter int               STEP      = 1,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         branch,
  input  logic                         zero,
  input  logic [WIDTH-1:0]             boffset,
  input  logic                         jump,
  input  logic                         call,
  input  logic [JADDR_W-1:0]           jaddr,
  input  logic                         jr,
  input  logic [WIDTH-1:0]             jr_target,
  input  logic                         ret,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus,
  output logic [$clog2(RAS_DEPTH):0]   ras_depth,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  localparam int               c_PW   = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] c_STEP = WIDTH'(STEP);
  localparam logic [c_PW:0]    c_FULL = (c_PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_stack [RAS_DEPTH];
  logic [c_PW-1:0]  r_ptr;
  logic [c_PW:0]    r_depth;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_jtarget;
  logic [WIDTH-1:0] w_br_target;
  logic [c_PW-1:0]  w_top;
  logic             w_push;
  logic             w_pop;
  logic             w_unf;

  generate
    if (JADDR_W >= WIDTH) begin : g_jaddr_trunc
      assign w_jtarget = jaddr[WIDTH-1:0];
    end else begin : g_jaddr_zext
      assign w_jtarget = {{(WIDTH-JADDR_W){1'b0}}, jaddr};
    end
  endgenerate

  assign pc          = r_pc;
  assign pc_plus     = r_pc + c_STEP;
  assign ras_depth   = r_depth;
  assign ras_empty   = (r_depth == '0);
  assign ras_full    = (r_depth == c_FULL);
  assign ras_ovf     = r_ovf;
  assign ras_unf     = r_unf;
  // r_ptr is the next free slot; the most recent push sits just below it
  assign w_top       = r_ptr - c_PW'(1);
  assign w_br_target = r_pc + c_STEP + boffset * c_STEP;

  always_comb begin
    w_pc_next = pc_plus;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_unf     = 1'b0;
    if (ret) begin
      if (!ras_empty) begin
        w_pc_next = r_stack[w_top];
        w_pop     = 1'b1;
      end else begin
        w_unf     = 1'b1;
      end
    end else if (jr) begin
      w_pc_next = jr_target;
    end else if (call) begin
      w_pc_next = w_jtarget;
      w_push    = 1'b1;
    end else if (jump) begin
      w_pc_next = w_jtarget;
    end else if (branch && zero) begin
      w_pc_next = w_br_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_VEC;
      r_ptr   <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!stall) begin
      r_pc <= w_pc_next;
      if (w_push) begin
        // a push while full overwrites the oldest slot, so depth saturates
        r_ptr <= r_ptr + c_PW'(1);
        if (ras_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_depth <= r_depth + (c_PW+1)'(1);
        end
      end
      if (w_pop) begin
        r_ptr   <= w_top;
        r_depth <= r_depth - (c_PW+1)'(1);
      end
      if (w_unf) begin
        r_unf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !stall && w_push) begin
      r_stack[r_ptr] <= pc_plus;
    end
  end

endmodule

`default_nettype wire
